router_fifo: RTL and testbench

ROUTER_FIFO -- requirements
Module: router_fifo

---
 rtl/router_pkg.sv | 7 +
 rtl/router_fifo_mem.sv | 67 ++++++
 rtl/router_fifo.sv | 116 +++++++++++
 tb/tb_router_fifo.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router constants used by the FIFO, sync and FSM stages.
package router_pkg;
  localparam int FIFO_DEPTH = 16;
  localparam int DATA_W     = 8;
  localparam int PTR_W      = 5;
  localparam int PKT_CNT_W  = 7;
endpackage

// File: rtl/router_fifo_mem.sv
// Router FIFO storage: DEPTH x (DATA_W+1) words, one synchronous write port
// and one synchronous read port. The payload array has no reset; the header
// flag per entry is cleared by resetn or clear. rd_hdr/rd_len expose the entry
// at rd_addr so the packet counter can load on the same edge as the read.
module router_fifo_mem #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int AW     = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W:0]   wr_word,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  input  logic              rd_zero,
  output logic              rd_hdr,
  output logic [DATA_W-3:0] rd_len,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  hdr_reg;
  logic [DEPTH-1:0]  hdr_we;

  // One-hot write decode for the header flags
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hdr_we
      assign hdr_we[gi] = wr_en && (wr_addr == AW'(gi));
    end
  endgenerate

  // Payload array write; no reset so it maps onto RAM
  always_ff @(posedge clock) begin
    if (wr_en) data_mem[wr_addr] <= wr_word[DATA_W-1:0];
  end

  // Header flags: cleared on reset/flush, captured with each write
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hdr_reg <= '0;
    end else if (clear) begin
      hdr_reg <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (hdr_we[i]) hdr_reg[i] <= wr_word[DATA_W];
      end
    end
  end

  assign rd_hdr = hdr_reg[rd_addr];
  assign rd_len = data_mem[rd_addr][DATA_W-1:2];

  // Registered read port; zeroed when idle outside a packet
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_data <= '0;
    end else if (clear) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= data_mem[rd_addr];
    end else if (rd_zero) begin
      rd_data <= '0;
    end
  end
endmodule

// File: rtl/router_fifo.sv
// Router output FIFO with header tagging and packet byte counter.
// Optional feature: define ROUTER_FIFO_ERR_EN to add the sticky err output
// (dropped write or ignored read); without it there is no err port.
module router_fifo #(
  parameter int DEPTH  = router_pkg::FIFO_DEPTH,
  parameter int DATA_W = router_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              read_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty
`ifdef ROUTER_FIFO_ERR_EN
  ,
  output logic              err
`endif
);
  import router_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]        wr_ptr_reg;
  logic [PW-1:0]        rd_ptr_reg;
  logic [PKT_CNT_W-1:0] pkt_cnt_reg;
  logic [PKT_CNT_W-1:0] pkt_cnt_next;
  logic                 wr_ok;
  logic                 rd_ok;
  logic                 rd_zero;
  logic                 rd_hdr;
  logic [DATA_W-3:0]    rd_len;

  // Pointers equal -> empty; only the wrap bits differ -> full
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // Each side is gated by its own flag before the edge; flush wins over both
  assign wr_ok   = write_enb && !full  && !soft_reset;
  assign rd_ok   = read_enb  && !empty && !soft_reset;
  assign rd_zero = (pkt_cnt_reg == '0) && !rd_ok;

  router_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_mem (
    .clock   (clock),
    .resetn  (resetn),
    .clear   (soft_reset),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr_reg[AW-1:0]),
    .wr_word ({lfd_state, data_in}),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr_reg[AW-1:0]),
    .rd_zero (rd_zero),
    .rd_hdr  (rd_hdr),
    .rd_len  (rd_len),
    .rd_data (data_out)
  );

  // Pointer advance, wrapping modulo 2*DEPTH through the wrap bit
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (soft_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (rd_ok) rd_ptr_reg <= rd_ptr_reg + PW'(1);
    end
  end

  // Header read loads length+parity; payload reads count down, saturating at 0
  always_comb begin
    pkt_cnt_next = pkt_cnt_reg;
    if (rd_ok) begin
      if (rd_hdr) begin
        pkt_cnt_next = PKT_CNT_W'(rd_len) + PKT_CNT_W'(1);
      end else if (pkt_cnt_reg != '0) begin
        pkt_cnt_next = pkt_cnt_reg - PKT_CNT_W'(1);
      end
    end
  end

  // Packet counter register; a flush abandons any packet in progress
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pkt_cnt_reg <= '0;
    end else if (soft_reset) begin
      pkt_cnt_reg <= '0;
    end else begin
      pkt_cnt_reg <= pkt_cnt_next;
    end
  end

`ifdef ROUTER_FIFO_ERR_EN
  // Sticky error on a dropped write or an ignored read
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      err <= 1'b0;
    end else if (soft_reset) begin
      err <= 1'b0;
    end else if ((write_enb && full) || (read_enb && empty)) begin
      err <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo.
module tb_router_fifo;
  logic       clock;
  logic       resetn;
  logic       soft_reset;
  logic       write_enb;
  logic       read_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
`ifdef ROUTER_FIFO_ERR_EN
  logic       err;
`endif

  int checks = 0;
  int errors = 0;

  router_fifo dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty)
`ifdef ROUTER_FIFO_ERR_EN
    ,
    .err        (err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic we, input logic re, input logic lfd,
                       input logic [7:0] d, input logic sr);
    write_enb  = we;
    read_enb   = re;
    lfd_state  = lfd;
    data_in    = d;
    soft_reset = sr;
  endtask

  task automatic wr(input logic [7:0] d, input logic lfd);
    drive(1'b1, 1'b0, lfd, d, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic rd();
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] pkt_exp [5];
    logic [6:0] cnt_exp [5];
    pkt_exp[0] = 8'h0D; pkt_exp[1] = 8'hAA; pkt_exp[2] = 8'hBB;
    pkt_exp[3] = 8'hCC; pkt_exp[4] = 8'hD0;
    cnt_exp[0] = 7'd4; cnt_exp[1] = 7'd3; cnt_exp[2] = 7'd2;
    cnt_exp[3] = 7'd1; cnt_exp[4] = 7'd0;

    resetn = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    #3;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_dout", 32'(data_out), 32'h0);
    chk("rst_pkt", 32'(dut.pkt_cnt_reg), 32'd0);
`ifdef ROUTER_FIFO_ERR_EN
    chk("rst_err", 32'(err), 32'd0);
`endif
    step();
    resetn = 1'b1;
    step();
    $display("reset released: empty=%0d full=%0d", empty, full);

    // Header 0D (len 3) + AA BB CC + parity D0, then five reads
    wr(8'h0D, 1'b1);
    wr(8'hAA, 1'b0);
    wr(8'hBB, 1'b0);
    wr(8'hCC, 1'b0);
    wr(8'hD0, 1'b0);
    chk("pkt_wr_empty", 32'(empty), 32'd0);
    chk("pkt_wr_dout", 32'(data_out), 32'h0);
    for (int i = 0; i < 5; i++) begin
      rd();
      $display("pkt read %0d: data_out=%h pkt_cnt=%0d", i, data_out, dut.pkt_cnt_reg);
      chk("pkt_rd_data", 32'(data_out), 32'(pkt_exp[i]));
      chk("pkt_rd_cnt", 32'(dut.pkt_cnt_reg), 32'(cnt_exp[i]));
    end
    step();
    chk("pkt_idle_dout", 32'(data_out), 32'h0);
    chk("pkt_idle_empty", 32'(empty), 32'd1);

    // Fill to 16, drop 17th, drain in order
    for (int i = 0; i < 16; i++) begin
      wr(8'h40 + 8'(i), 1'b0);
      if (i == 14) chk("fill_full15", 32'(full), 32'd0);
    end
    chk("fill_full16", 32'(full), 32'd1);
    wr(8'hFF, 1'b0);
    $display("17th write: full=%0d", full);
    chk("drop_full", 32'(full), 32'd1);
`ifdef ROUTER_FIFO_ERR_EN
    chk("drop_err", 32'(err), 32'd1);
`endif
    for (int i = 0; i < 16; i++) begin
      rd();
      $display("drain read %0d: data_out=%h", i, data_out);
      chk("drain_data", 32'(data_out), 32'h40 + 32'(i));
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_pkt", 32'(dut.pkt_cnt_reg), 32'd0);
    step();
    chk("drain_idle_dout", 32'(data_out), 32'h0);

    // Full with both strobes: only the read happens
    for (int i = 0; i < 16; i++) wr(8'h60 + 8'(i), 1'b0);
    chk("both_full_pre", 32'(full), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 8'hEE, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    $display("both while full: data_out=%h full=%0d", data_out, full);
    chk("both_full_dout", 32'(data_out), 32'h60);
    chk("both_full_flag", 32'(full), 32'd0);
    for (int i = 1; i < 16; i++) begin
      rd();
      chk("both_full_drain", 32'(data_out), 32'h60 + 32'(i));
    end
    chk("both_full_empty", 32'(empty), 32'd1);

    // Empty with both strobes: only the write happens, data_out holds
    wr(8'h09, 1'b1);
    rd();
    chk("both_empty_hdr", 32'(data_out), 32'h09);
    chk("both_empty_cnt", 32'(dut.pkt_cnt_reg), 32'd3);
    drive(1'b1, 1'b1, 1'b0, 8'h5A, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    $display("both while empty: data_out=%h empty=%0d", data_out, empty);
    chk("both_empty_dout", 32'(data_out), 32'h09);
    chk("both_empty_flag", 32'(empty), 32'd0);
    rd();
    chk("both_empty_rd", 32'(data_out), 32'h5A);
    chk("both_empty_cnt2", 32'(dut.pkt_cnt_reg), 32'd2);
    step();
    chk("hold_in_pkt", 32'(data_out), 32'h5A);

    // Soft reset with a concurrent write
    for (int i = 0; i < 5; i++) wr(8'h70 + 8'(i), 1'b0);
    chk("sr_pre_empty", 32'(empty), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 8'h99, 1'b1);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    $display("soft reset: empty=%0d data_out=%h", empty, data_out);
    chk("sr_empty", 32'(empty), 32'd1);
    chk("sr_dout", 32'(data_out), 32'h0);
    chk("sr_pkt", 32'(dut.pkt_cnt_reg), 32'd0);
    step();
    chk("sr_wr_dropped", 32'(empty), 32'd1);
    wr(8'h31, 1'b1);
    rd();
    chk("sr_restart_dout", 32'(data_out), 32'h31);
    chk("sr_restart_cnt", 32'(dut.pkt_cnt_reg), 32'd13);

    // Asynchronous reset mid-packet, between edges
    wr(8'h80, 1'b0);
    wr(8'h81, 1'b0);
    rd();
    chk("ar_pre_dout", 32'(data_out), 32'h80);
    chk("ar_pre_cnt", 32'(dut.pkt_cnt_reg), 32'd12);
    #2;
    resetn = 1'b0;
    #1;
    $display("async reset: empty=%0d full=%0d data_out=%h", empty, full, data_out);
    chk("ar_empty", 32'(empty), 32'd1);
    chk("ar_full", 32'(full), 32'd0);
    chk("ar_dout", 32'(data_out), 32'h0);
    chk("ar_pkt", 32'(dut.pkt_cnt_reg), 32'd0);
    #1;
    resetn = 1'b1;
    step();
    chk("ar_post_empty", 32'(empty), 32'd1);
    wr(8'h05, 1'b1);
    rd();
    chk("ar_restart_dout", 32'(data_out), 32'h05);
    chk("ar_restart_cnt", 32'(dut.pkt_cnt_reg), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
